costas_gain_sched: RTL and testbench
====================================

Name: costas_gain_sched

Overview:
Lock-aware controller for the Costas carrier-recovery loop. It watches the loop's phase-error stream and runs a window-averaged lock detector. It drives the loop's alpha/beta gains: wide gains during acquisition, narrow gains during tracking. It also pulses a clear to the loop's phase/freq state on start, acquisition timeout and loss of lock.

Parameters:
WIN_LOG2, 4, log2 of error samples per averaging window (16)
LOCK_WINDOWS, 3, consecutive windows with avg < lock_thresh needed to declare lock
UNLOCK_WINDOWS, 2, consecutive windows with avg > unlock_thresh needed to declare loss of lock
ACQ_TIMEOUT, 8, windows allowed in ACQUIRE before forced re-clear

Ports:
s00_axis_aclk  in  1  clock
s00_axis_areset  in  1  asynchronous reset, active-high
enable  in  1  level; 1 = run loop, 0 = freeze (IDLE)
err_valid  in  1  one error sample this cycle
err_data  in  16  signed phase error from the loop
acq_alpha, acq_beta  in  17 each  acquisition gains
trk_alpha, trk_beta  in  17 each  tracking gains
lock_thresh, unlock_thresh  in  16 each  unsigned avg |error| thresholds
alpha_out, beta_out  out  17 each  registered gains to the loop
gain_update  out  1  1-cycle pulse when alpha_out/beta_out change
loop_clear  out  1  high for exactly the cycle spent in CLEAR
locked  out  1  state == TRACK
state  out  2  IDLE=0, CLEAR=1, ACQUIRE=2, TRACK=3
window_avg  out  16  last completed window average
retry_count  out  8  timeouts + unlocks since leaving IDLE, saturating

Behaviour:
- Reset (async, any time, incl. mid-window): state=IDLE; alpha_out=beta_out=0; gain_update=loop_clear=locked=0; window_avg=0; retry_count=0; all internal counters and accumulator=0.
- |err|: two's-complement abs, saturating: -32768 -> 32767. Accumulator width 16+WIN_LOG2, never overflows. avg = (acc + |err_final|) >> WIN_LOG2, truncating.
- Samples are counted only when err_valid=1 in ACQUIRE or TRACK; they are ignored in IDLE/CLEAR. A window completes on the edge that accepts sample 2^WIN_LOG2. On that edge: window_avg is loaded, the accumulator and sample counter are cleared, the window counters update, and any resulting transition is taken. The new state is visible the next cycle (1-cycle latency).
- IDLE: gains 0. enable=1 -> CLEAR.
- CLEAR: one cycle; loop_clear=1. The accumulator, sample counter, lock/unlock/acq-window counters are cleared. alpha_out/beta_out <= acq gains and gain_update=1 on that edge. Next state is ACQUIRE.
- ACQUIRE: on each window, avg < lock_thresh increments lock_cnt, otherwise lock_cnt resets to 0. acq_cnt increments each window.
  - lock_cnt reaching LOCK_WINDOWS -> TRACK. Gains <= trk gains, gain_update=1.
  - Otherwise, acq_cnt reaching ACQ_TIMEOUT -> CLEAR, retry_count+1.
  - If both occur on the same window, lock wins.
- TRACK: on each window, avg > unlock_thresh increments unlock_cnt, otherwise it resets to 0. unlock_cnt reaching UNLOCK_WINDOWS -> CLEAR, retry_count+1.
- Thresholds use strict comparisons; avg equal to a threshold is neither lock nor unlock evidence.
- enable=0 in any state -> IDLE on the next edge. This overrides a simultaneous window completion or transition. Gains go to 0, with gain_update=1 if they were nonzero. retry_count clears on entering IDLE.
- gain_update fires only if the new gain values differ from the current ones.
- Gain inputs are sampled only on transition edges and are otherwise don't-care.
- retry_count saturates at 255.

Decomposition:
- Package costas_pkg holds: state enum typedef (2-bit), ERR_W=16, GAIN_W=17, and an abs_sat function.
- One sub-module, err_window_avg: accumulator, sample counter, window_done pulse and avg output. The FSM and counters stay in the top level.

Test Plan:
- enable=1, err_data=+10 constant, lock_thresh=100 -> CLEAR 1 cycle (alpha_out=acq_alpha), then TRACK 1 cycle after sample 48; locked=1, window_avg=10, gain_update pulse, alpha_out=trk_alpha.
- err_data=-32768 constant x16 -> window_avg=32767 (saturated abs).
- err_data=+500, lock_thresh=100 -> after 8 windows (128 samples): loop_clear pulse, retry_count=1, then ACQUIRE again with acq gains.
- Locked, then err_data=+2000 with unlock_thresh=1000 -> CLEAR after 2 windows; the next cycle is ACQUIRE; retry_count increments.
- enable deasserted on the same cycle as the locking window's final sample -> IDLE next cycle, alpha_out=beta_out=0, retry_count=0, no TRACK.
- Assert reset after 7 samples of a window, then release with enable=1 -> all outputs at reset values; the next lock takes a full 3x16 samples after CLEAR.

Source files
------------

// File: rtl/costas_gain_sched_pkg.sv
// Shared types and helpers for the Costas loop gain scheduler.
package costas_pkg;

  localparam int ERR_W  = 16;
  localparam int GAIN_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_TRACK   = 2'd3
  } state_e;

  // Magnitude of a two's-complement error; the most negative code maps to the most positive.
  function automatic logic [ERR_W-1:0] abs_sat(input logic signed [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {1'b1, {(ERR_W-1){1'b0}}}) r = {1'b0, {(ERR_W-1){1'b1}}};
    else if (v[ERR_W-1])                r = ERR_W'(-v);
    else                                r = v;
    return r;
  endfunction

endpackage

// File: rtl/costas_gain_sched_if.sv
// Error stream, gain/threshold configuration and scheduler outputs for the Costas loop.
interface costas_gain_sched_if;
  import costas_pkg::*;

  logic                     enable;
  logic                     err_valid;
  logic signed [ERR_W-1:0]  err_data;
  logic [GAIN_W-1:0]        acq_alpha;
  logic [GAIN_W-1:0]        acq_beta;
  logic [GAIN_W-1:0]        trk_alpha;
  logic [GAIN_W-1:0]        trk_beta;
  logic [ERR_W-1:0]         lock_thresh;
  logic [ERR_W-1:0]         unlock_thresh;
  logic [GAIN_W-1:0]        alpha_out;
  logic [GAIN_W-1:0]        beta_out;
  logic                     gain_update;
  logic                     loop_clear;
  logic                     locked;
  state_e                   state;
  logic [ERR_W-1:0]         window_avg;
  logic [7:0]               retry_count;

  // err_valid qualifies err_data for exactly one cycle; there is no backpressure.
  modport master (
    output enable, err_valid, err_data, acq_alpha, acq_beta, trk_alpha, trk_beta,
           lock_thresh, unlock_thresh,
    input  alpha_out, beta_out, gain_update, loop_clear, locked, state, window_avg, retry_count
  );

  modport slave (
    input  enable, err_valid, err_data, acq_alpha, acq_beta, trk_alpha, trk_beta,
           lock_thresh, unlock_thresh,
    output alpha_out, beta_out, gain_update, loop_clear, locked, state, window_avg, retry_count
  );
endinterface

// File: rtl/costas_gain_sched_err_window_avg.sv
// Accumulates |error| over fixed-size windows and reports each completed window's mean.
module err_window_avg
  import costas_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    sample_en,
  input  logic signed [ERR_W-1:0] err_data,
  output logic                    window_done,
  output logic [ERR_W-1:0]        avg_new,
  output logic [ERR_W-1:0]        avg
);

  localparam int ACC_W = ERR_W + WIN_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    sum;
  logic [WIN_LOG2-1:0] cnt_q;

  assign sum         = acc_q + ACC_W'(abs_sat(err_data));
  assign window_done = sample_en && (cnt_q == '1);
  // Average including the sample being accepted this cycle, so the controller can act on it now.
  assign avg_new     = ERR_W'(sum >> WIN_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg   <= '0;
    end else if (clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (sample_en) begin
      if (window_done) begin
        acc_q <= '0;
        cnt_q <= '0;
        avg   <= avg_new;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/costas_gain_sched.sv
// Lock detector and gain scheduler: wide gains while acquiring, narrow gains while tracking.
module costas_gain_sched #(
  parameter int WIN_LOG2       = 4,
  parameter int LOCK_WINDOWS   = 3,
  parameter int UNLOCK_WINDOWS = 2,
  parameter int ACQ_TIMEOUT    = 8
) (
  input logic                s00_axis_aclk,
  input logic                s00_axis_areset,
  costas_gain_sched_if.slave bus
);
  import costas_pkg::*;

  state_e            state_q, state_n;
  logic [GAIN_W-1:0] alpha_q, alpha_n, beta_q, beta_n;
  logic              gain_update_q, gain_update_n;
  logic [7:0]        lock_q, lock_n, unlock_q, unlock_n, acq_q, acq_n, retry_q, retry_n;
  logic              sample_en, window_done;
  logic [ERR_W-1:0]  avg_new, avg;

  assign sample_en = bus.enable && bus.err_valid &&
                     (state_q == ST_ACQUIRE || state_q == ST_TRACK);

  err_window_avg #(.WIN_LOG2(WIN_LOG2)) u_win (
    .clk         (s00_axis_aclk),
    .rst         (s00_axis_areset),
    .clear       (state_q == ST_CLEAR),
    .sample_en   (sample_en),
    .err_data    (bus.err_data),
    .window_done (window_done),
    .avg_new     (avg_new),
    .avg         (avg)
  );

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q       <= ST_IDLE;
      alpha_q       <= '0;
      beta_q        <= '0;
      gain_update_q <= 1'b0;
      lock_q        <= '0;
      unlock_q      <= '0;
      acq_q         <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_n;
      alpha_q       <= alpha_n;
      beta_q        <= beta_n;
      gain_update_q <= gain_update_n;
      lock_q        <= lock_n;
      unlock_q      <= unlock_n;
      acq_q         <= acq_n;
      retry_q       <= retry_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    alpha_n  = alpha_q;
    beta_n   = beta_q;
    lock_n   = lock_q;
    unlock_n = unlock_q;
    acq_n    = acq_q;
    retry_n  = retry_q;
    // Dropping enable wins over anything a completing window would have done.
    if (!bus.enable) begin
      state_n  = ST_IDLE;
      alpha_n  = '0;
      beta_n   = '0;
      lock_n   = '0;
      unlock_n = '0;
      acq_n    = '0;
      retry_n  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n = ST_CLEAR;
          alpha_n = bus.acq_alpha;
          beta_n  = bus.acq_beta;
        end
        ST_CLEAR: begin
          state_n  = ST_ACQUIRE;
          lock_n   = '0;
          unlock_n = '0;
          acq_n    = '0;
        end
        ST_ACQUIRE: begin
          if (window_done) begin
            lock_n = (avg_new < bus.lock_thresh) ? lock_q + 8'd1 : 8'd0;
            acq_n  = acq_q + 8'd1;
            if (lock_n == 8'(LOCK_WINDOWS)) begin
              state_n  = ST_TRACK;
              alpha_n  = bus.trk_alpha;
              beta_n   = bus.trk_beta;
              unlock_n = '0;
            end else if (acq_n == 8'(ACQ_TIMEOUT)) begin
              state_n = ST_CLEAR;
              alpha_n = bus.acq_alpha;
              beta_n  = bus.acq_beta;
              retry_n = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
            end
          end
        end
        ST_TRACK: begin
          if (window_done) begin
            unlock_n = (avg_new > bus.unlock_thresh) ? unlock_q + 8'd1 : 8'd0;
            if (unlock_n == 8'(UNLOCK_WINDOWS)) begin
              state_n = ST_CLEAR;
              alpha_n = bus.acq_alpha;
              beta_n  = bus.acq_beta;
              retry_n = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    gain_update_n = (alpha_n != alpha_q) || (beta_n != beta_q);
  end

  assign bus.alpha_out   = alpha_q;
  assign bus.beta_out    = beta_q;
  assign bus.gain_update = gain_update_q;
  assign bus.loop_clear  = (state_q == ST_CLEAR);
  assign bus.locked      = (state_q == ST_TRACK);
  assign bus.state       = state_q;
  assign bus.window_avg  = avg;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_costas_gain_sched.sv
// Bench for costas_gain_sched: vector table, directed corner sequences, randomized model check.
module tb_costas_gain_sched;
  import costas_pkg::*;

  localparam logic [16:0] ACQ_A = 17'd1200;
  localparam logic [16:0] ACQ_B = 17'd300;
  localparam logic [16:0] TRK_A = 17'd150;
  localparam logic [16:0] TRK_B = 17'd20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  costas_gain_sched_if bus();

  costas_gain_sched #(
    .WIN_LOG2(4), .LOCK_WINDOWS(3), .UNLOCK_WINDOWS(2), .ACQ_TIMEOUT(8)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .bus             (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic signed [15:0] err;
    int                 n;
    logic [15:0]        lt;
    logic [15:0]        ut;
    int                 exp_state;
    int                 exp_avg;
    int                 exp_retry;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.enable        = 1'b0;
    bus.err_valid     = 1'b0;
    bus.err_data      = '0;
    bus.acq_alpha     = ACQ_A;
    bus.acq_beta      = ACQ_B;
    bus.trk_alpha     = TRK_A;
    bus.trk_beta      = TRK_B;
    bus.lock_thresh   = 16'd100;
    bus.unlock_thresh = 16'd1000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start_acq();
    bus.enable = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic feed(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.err_valid = 1'b1;
      bus.err_data  = v;
      cyc();
    end
    bus.err_valid = 1'b0;
  endtask

  // Reference model: window held as a list of magnitudes, averaged by plain arithmetic.
  int m_state, m_alpha, m_beta, m_gu, m_avg, m_retry;
  int m_lock_run, m_unlock_run, m_windows;
  int m_win[$];
  int r_acq_a, r_acq_b, r_trk_a, r_trk_b, r_lt, r_ut;

  function automatic int mag(input int e);
    if (e == -32768) return 32767;
    return (e < 0) ? -e : e;
  endfunction

  task automatic model_reset();
    m_state = 0; m_alpha = 0; m_beta = 0; m_gu = 0; m_avg = 0; m_retry = 0;
    m_lock_run = 0; m_unlock_run = 0; m_windows = 0;
    m_win.delete();
  endtask

  task automatic model_step(input bit en, input bit valid, input int e);
    int  na, nb, ns, s;
    bit  done;
    na = m_alpha; nb = m_beta; ns = m_state; done = 0;
    if (!en) begin
      ns = 0; na = 0; nb = 0; m_retry = 0;
    end else if (m_state == 0) begin
      ns = 1; na = r_acq_a; nb = r_acq_b;
    end else if (m_state == 1) begin
      ns = 2; m_win.delete(); m_lock_run = 0; m_unlock_run = 0; m_windows = 0;
    end else if (valid) begin
      m_win.push_back(mag(e));
      if (m_win.size() == 16) begin
        s = 0;
        foreach (m_win[k]) s += m_win[k];
        m_avg = s / 16;
        m_win.delete();
        done = 1;
      end
    end
    if (done && m_state == 2) begin
      m_windows++;
      m_lock_run = (m_avg < r_lt) ? m_lock_run + 1 : 0;
      if (m_lock_run == 3) begin
        ns = 3; na = r_trk_a; nb = r_trk_b; m_unlock_run = 0;
      end else if (m_windows == 8) begin
        ns = 1; na = r_acq_a; nb = r_acq_b; m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      end
    end else if (done && m_state == 3) begin
      m_unlock_run = (m_avg > r_ut) ? m_unlock_run + 1 : 0;
      if (m_unlock_run == 2) begin
        ns = 1; na = r_acq_a; nb = r_acq_b; m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      end
    end
    m_gu    = (na != m_alpha || nb != m_beta) ? 1 : 0;
    m_alpha = na;
    m_beta  = nb;
    m_state = ns;
  endtask

  initial begin
    int base, mg;
    logic signed [15:0] d;

    vecs[0] = '{err: 16'sd10,     n: 48,  lt: 16'd100, ut: 16'd1000, exp_state: 3, exp_avg: 10,    exp_retry: 0};
    vecs[1] = '{err: -16'sd32768, n: 16,  lt: 16'd100, ut: 16'd1000, exp_state: 2, exp_avg: 32767, exp_retry: 0};
    vecs[2] = '{err: 16'sd500,    n: 128, lt: 16'd100, ut: 16'd1000, exp_state: 1, exp_avg: 500,   exp_retry: 1};
    vecs[3] = '{err: 16'sd100,    n: 48,  lt: 16'd100, ut: 16'd1000, exp_state: 2, exp_avg: 100,   exp_retry: 0};
    vecs[4] = '{err: 16'sd99,     n: 48,  lt: 16'd100, ut: 16'd1000, exp_state: 3, exp_avg: 99,    exp_retry: 0};
    vecs[5] = '{err: -16'sd7,     n: 32,  lt: 16'd100, ut: 16'd1000, exp_state: 2, exp_avg: 7,     exp_retry: 0};
    vecs[6] = '{err: 16'sd32767,  n: 16,  lt: 16'd100, ut: 16'd1000, exp_state: 2, exp_avg: 32767, exp_retry: 0};
    vecs[7] = '{err: 16'sd0,      n: 47,  lt: 16'd1,   ut: 16'd1000, exp_state: 2, exp_avg: 0,     exp_retry: 0};
    vecs[8] = '{err: -16'sd32768, n: 48,  lt: 16'd100, ut: 16'd1000, exp_state: 2, exp_avg: 32767, exp_retry: 0};

    // Reset values.
    do_reset();
    check("rst_state", 32'(bus.state), 0);
    check("rst_alpha", 32'(bus.alpha_out), 0);
    check("rst_beta", 32'(bus.beta_out), 0);
    check("rst_gain_update", 32'(bus.gain_update), 0);
    check("rst_loop_clear", 32'(bus.loop_clear), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_window_avg", 32'(bus.window_avg), 0);
    check("rst_retry", 32'(bus.retry_count), 0);

    // Constant-error vectors from a fresh start.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      bus.lock_thresh   = vecs[v].lt;
      bus.unlock_thresh = vecs[v].ut;
      start_acq();
      feed(vecs[v].err, vecs[v].n);
      check($sformatf("vec%0d_state", v), 32'(bus.state), 32'(vecs[v].exp_state));
      check($sformatf("vec%0d_avg", v), 32'(bus.window_avg), 32'(vecs[v].exp_avg));
      check($sformatf("vec%0d_retry", v), 32'(bus.retry_count), 32'(vecs[v].exp_retry));
    end

    // Startup, lock, then loss of lock.
    do_reset();
    bus.enable = 1'b1;
    cyc();
    check("start_clear_state", 32'(bus.state), 1);
    check("start_loop_clear", 32'(bus.loop_clear), 1);
    check("start_alpha", 32'(bus.alpha_out), 32'(ACQ_A));
    check("start_beta", 32'(bus.beta_out), 32'(ACQ_B));
    check("start_gain_update", 32'(bus.gain_update), 1);
    cyc();
    check("start_acq_state", 32'(bus.state), 2);
    check("start_acq_loop_clear", 32'(bus.loop_clear), 0);
    check("start_acq_gain_update", 32'(bus.gain_update), 0);
    feed(16'sd10, 47);
    check("lock_47_state", 32'(bus.state), 2);
    feed(16'sd10, 1);
    check("lock_state", 32'(bus.state), 3);
    check("lock_locked", 32'(bus.locked), 1);
    check("lock_alpha", 32'(bus.alpha_out), 32'(TRK_A));
    check("lock_beta", 32'(bus.beta_out), 32'(TRK_B));
    check("lock_gain_update", 32'(bus.gain_update), 1);
    cyc();
    check("lock_gain_update_drop", 32'(bus.gain_update), 0);
    feed(16'sd2000, 16);
    check("unlock_1win_state", 32'(bus.state), 3);
    check("unlock_1win_avg", 32'(bus.window_avg), 2000);
    feed(16'sd2000, 16);
    check("unlock_state", 32'(bus.state), 1);
    check("unlock_loop_clear", 32'(bus.loop_clear), 1);
    check("unlock_retry", 32'(bus.retry_count), 1);
    check("unlock_alpha", 32'(bus.alpha_out), 32'(ACQ_A));
    check("unlock_gain_update", 32'(bus.gain_update), 1);
    cyc();
    check("unlock_next_state", 32'(bus.state), 2);

    // Acquisition timeout, then enable drops on the locking window's last sample.
    do_reset();
    start_acq();
    feed(16'sd500, 127);
    check("timeout_127_state", 32'(bus.state), 2);
    feed(16'sd500, 1);
    check("timeout_state", 32'(bus.state), 1);
    check("timeout_retry", 32'(bus.retry_count), 1);
    check("timeout_alpha", 32'(bus.alpha_out), 32'(ACQ_A));
    check("timeout_gain_update", 32'(bus.gain_update), 0);
    cyc();
    check("timeout_next_state", 32'(bus.state), 2);
    feed(16'sd10, 47);
    bus.err_valid = 1'b1;
    bus.err_data  = 16'sd10;
    bus.enable    = 1'b0;
    cyc();
    bus.err_valid = 1'b0;
    check("dis_state", 32'(bus.state), 0);
    check("dis_locked", 32'(bus.locked), 0);
    check("dis_alpha", 32'(bus.alpha_out), 0);
    check("dis_beta", 32'(bus.beta_out), 0);
    check("dis_retry", 32'(bus.retry_count), 0);
    check("dis_gain_update", 32'(bus.gain_update), 1);
    cyc();
    check("dis_hold_state", 32'(bus.state), 0);
    check("dis_gain_update_drop", 32'(bus.gain_update), 0);

    // Asynchronous reset partway through a window.
    do_reset();
    start_acq();
    feed(16'sd10, 16 + 7);
    #3;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.state), 0);
    check("arst_alpha", 32'(bus.alpha_out), 0);
    check("arst_gain_update", 32'(bus.gain_update), 0);
    check("arst_window_avg", 32'(bus.window_avg), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check("arst_clear_state", 32'(bus.state), 1);
    cyc();
    feed(16'sd10, 47);
    check("arst_47_state", 32'(bus.state), 2);
    feed(16'sd10, 1);
    check("arst_lock_state", 32'(bus.state), 3);

    // Randomized error stream in regimes against the reference model.
    do_reset();
    r_acq_a = $urandom_range(1, 131071);
    r_acq_b = $urandom_range(1, 131071);
    r_trk_a = $urandom_range(1, 131071);
    r_trk_b = $urandom_range(1, 131071);
    r_lt    = 100;
    r_ut    = $urandom_range(200, 400);
    bus.acq_alpha     = 17'(r_acq_a);
    bus.acq_beta      = 17'(r_acq_b);
    bus.trk_alpha     = 17'(r_trk_a);
    bus.trk_beta      = 17'(r_trk_b);
    bus.lock_thresh   = 16'(r_lt);
    bus.unlock_thresh = 16'(r_ut);
    bus.enable        = 1'b1;
    model_reset();
    base = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       base = $urandom_range(0, 60);
          1:       base = $urandom_range(150, 350);
          default: base = $urandom_range(450, 3000);
        endcase
      end
      mg = base + $urandom_range(0, 20);
      d  = ($urandom_range(0, 1) == 1) ? 16'(-mg) : 16'(mg);
      if ($urandom_range(0, 63) == 0) d = -16'sd32768;
      bus.err_valid = ($urandom_range(0, 3) != 0);
      bus.err_data  = d;
      model_step(1'b1, bus.err_valid, int'(d));
      cyc();
      check("rnd_state", 32'(bus.state), 32'(m_state));
      check("rnd_alpha", 32'(bus.alpha_out), 32'(m_alpha));
      check("rnd_beta", 32'(bus.beta_out), 32'(m_beta));
      check("rnd_gain_update", 32'(bus.gain_update), 32'(m_gu));
      check("rnd_loop_clear", 32'(bus.loop_clear), (m_state == 1) ? 32'd1 : 32'd0);
      check("rnd_locked", 32'(bus.locked), (m_state == 3) ? 32'd1 : 32'd0);
      check("rnd_window_avg", 32'(bus.window_avg), 32'(m_avg));
      check("rnd_retry", 32'(bus.retry_count), 32'(m_retry));
    end
    bus.err_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
